// File: rtl/encrypt_store_ctrl.sv
// rtl/encrypt_store_ctrl.sv - encrypt-and-store sequencer: rotate, shift-add multiply, write to store
// One request in flight at a time; a registered host read port runs independently of the write path.
module encrypt_store_ctrl #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 16,
  parameter int ROT_STEPS = 2,
  parameter int WRAP      = 0,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_num,
  input  logic [WIDTH-1:0]   in_key,
  output logic               in_ready,
  input  logic               clear,
  output logic               done,
  output logic [AW-1:0]      done_addr,
  output logic [2*WIDTH-1:0] done_data,
  output logic               full,
  output logic [AW:0]        count,
  input  logic               rd_req,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_valid,
  output logic [2*WIDTH-1:0] rd_data
);

  localparam int CW       = AW + 1;
  localparam int CNTMAX   = (ROT_STEPS > WIDTH) ? ROT_STEPS : WIDTH;
  localparam int CNTW     = $clog2(CNTMAX + 1);
  localparam int ROT_LAST = (ROT_STEPS > 0) ? ROT_STEPS - 1 : 0;

  typedef enum logic [1:0] {IDLE, ROT, MUL, WR} state_t;

  state_t              state_q;
  logic [CNTW-1:0]     cnt_q;
  logic [WIDTH-1:0]    q_q, a_q, m_q;
  logic [AW-1:0]       wr_ptr_q;
  logic [CW-1:0]       count_q;
  logic                full_q;
  logic                done_q;
  logic [AW-1:0]       done_addr_q;
  logic [2*WIDTH-1:0]  done_data_q;
  logic                rd_valid_q;
  logic [2*WIDTH-1:0]  rd_data_q;
  logic [2*WIDTH-1:0]  mem [DEPTH];

  logic [WIDTH:0]      sum;
  logic [WIDTH-1:0]    a_d, q_d;
  logic [2*WIDTH-1:0]  product;
  logic                wr_en;

  assign in_ready = (state_q == IDLE) && (!full_q || (WRAP != 0));
  assign product  = {a_q, q_q};
  assign wr_en    = (state_q == WR) && !clear;
  assign sum      = {1'b0, a_q} + {1'b0, m_q};

  // One shift-add step on {C,A,Q}: conditional add, then shift the whole triple right.
  always_comb begin
    a_d = {1'b0, a_q[WIDTH-1:1]};
    q_d = {a_q[0], q_q[WIDTH-1:1]};
    if (q_q[0]) begin
      a_d = sum[WIDTH:1];
      q_d = {sum[0], q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      a_q         <= '0;
      m_q         <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      done_addr_q <= '0;
      done_data_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (clear) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        full_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (in_valid && in_ready) begin
              q_q     <= in_num;
              m_q     <= in_key;
              a_q     <= '0;
              cnt_q   <= '0;
              state_q <= (ROT_STEPS == 0) ? MUL : ROT;
            end
          end
          ROT: begin
            q_q   <= {q_q[0], q_q[WIDTH-1:1]};
            cnt_q <= cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(ROT_LAST)) begin
              cnt_q   <= '0;
              state_q <= MUL;
            end
          end
          MUL: begin
            a_q   <= a_d;
            q_q   <= q_d;
            cnt_q <= cnt_q + CNTW'(1);
            if (cnt_q == CNTW'(WIDTH - 1)) begin
              cnt_q   <= '0;
              state_q <= WR;
            end
          end
          WR: begin
            done_q      <= 1'b1;
            done_addr_q <= wr_ptr_q;
            done_data_q <= product;
            wr_ptr_q    <= wr_ptr_q + AW'(1);
            if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
            full_q      <= (count_q >= CW'(DEPTH - 1));
            state_q     <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Store is not reset; nonblocking write gives read-before-write on a shared edge.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= product;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_req;
      if (rd_req) rd_data_q <= mem[rd_addr];
    end
  end

  assign done      = done_q;
  assign done_addr = done_addr_q;
  assign done_data = done_data_q;
  assign full      = full_q;
  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule

// File: tb/tb_encrypt_store_ctrl.sv
// tb/tb_encrypt_store_ctrl.sv - self-checking bench for encrypt_store_ctrl
module tb_encrypt_store_ctrl;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic [3:0] in_num, in_key;
  logic       in_ready;
  logic       clear;
  logic       done;
  logic [3:0] done_addr;
  logic [7:0] done_data;
  logic       full;
  logic [4:0] count;
  logic       rd_req;
  logic [3:0] rd_addr;
  logic       rd_valid;
  logic [7:0] rd_data;

  int tests_run = 0;
  int tests_failed = 0;

  encrypt_store_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_num(in_num), .in_key(in_key), .in_ready(in_ready),
    .clear(clear), .done(done), .done_addr(done_addr), .done_data(done_data),
    .full(full), .count(count),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] num;
    logic [3:0] key;
    logic [7:0] exp;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] exp_mem [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model(input logic [3:0] n, input logic [3:0] k);
    logic [3:0] r;
    r = {n[1:0], n[3:2]};
    return {4'b0, r} * {4'b0, k};
  endfunction

  // Called at a negedge with in_ready high; returns at the negedge where done is seen.
  task automatic do_op(input logic [3:0] n, input logic [3:0] k, output int lat,
                       output logic [3:0] addr, output logic [7:0] data, output int low_cnt);
    lat = -1; low_cnt = 0; addr = '0; data = '0;
    in_num = n; in_key = k; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0; in_num = 4'($urandom); in_key = 4'($urandom);
    for (int i = 0; i < 20 && lat < 0; i++) begin
      if (!in_ready) low_cnt++;
      if (done) begin
        lat = i; addr = done_addr; data = done_data;
      end else begin
        @(negedge clock);
      end
    end
  endtask

  task automatic do_read(input logic [3:0] a, output logic v, output logic [7:0] d);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clock);
    rd_req = 1'b0;
    v = rd_valid; d = rd_data;
  endtask

  task automatic watch_no_done(input int cycles, output logic seen);
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clock);
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    int         lat, low;
    logic [3:0] a;
    logic [7:0] d;
    logic       v, seen;

    reset_n = 1'b0; in_valid = 1'b0; in_num = '0; in_key = '0;
    clear = 1'b0; rd_req = 1'b0; rd_addr = '0;

    vecs[0] = '{4'b1000, 4'b1000, 8'h10};
    vecs[1] = '{4'b1001, 4'b1000, 8'h30};
    vecs[2] = '{4'b1100, 4'b1010, 8'h1E};
    vecs[3] = '{4'b1011, 4'b1110, 8'hC4};
    vecs[4] = '{4'b0000, 4'b1111, 8'h00};
    vecs[5] = '{4'b1111, 4'b1111, 8'hE1};
    vecs[6] = '{4'b0001, 4'b0011, 8'h0C};

    repeat (2) @(negedge clock);
    check("rst_done", done, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_done_data", done_data, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", in_ready, 1);

    // Back-to-back table ops
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].num, vecs[i].key, lat, a, d, low);
      check($sformatf("op%0d_latency", i), lat, 7);
      check($sformatf("op%0d_ready_low", i), low, 7);
      check($sformatf("op%0d_addr", i), a, i);
      check($sformatf("op%0d_data", i), d, vecs[i].exp);
      check($sformatf("op%0d_count", i), count, i + 1);
      exp_mem[i] = vecs[i].exp;
    end
    @(negedge clock);
    check("done_pulse", done, 0);

    for (int i = 0; i < 7; i++) begin
      do_read(4'(i), v, d);
      check($sformatf("rd%0d_valid", i), v, 1);
      check($sformatf("rd%0d_data", i), d, exp_mem[i]);
    end

    // Fill to DEPTH
    for (int i = 7; i < 16; i++) begin
      do_op(4'(i), 4'(15 - i), lat, a, d, low);
      check($sformatf("fill%0d_addr", i), a, i);
      check($sformatf("fill%0d_data", i), d, model(4'(i), 4'(15 - i)));
      exp_mem[i] = model(4'(i), 4'(15 - i));
    end
    @(negedge clock);
    check("full_flag", full, 1);
    check("full_count", count, 16);
    check("full_in_ready", in_ready, 0);
    in_valid = 1'b1;
    watch_no_done(12, seen);
    in_valid = 1'b0;
    check("full_no_accept", seen, 0);
    check("full_count_hold", count, 16);
    do_read(4'd5, v, d);
    check("full_rd5", d, exp_mem[5]);

    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_count", count, 0);
    check("clr_full", full, 0);
    check("clr_in_ready", in_ready, 1);

    // clear and in_valid on the same edge: not accepted
    clear = 1'b1; in_valid = 1'b1; in_num = 4'b0110; in_key = 4'b0110;
    @(negedge clock);
    clear = 1'b0; in_valid = 1'b0;
    check("clr_valid_ready", in_ready, 1);
    watch_no_done(10, seen);
    check("clr_valid_no_done", seen, 0);
    do_read(4'd5, v, d);
    check("clr_rd5", d, exp_mem[5]);

    // Read-before-write at addr 0
    in_num = 4'b0011; in_key = 4'b0101; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (6) @(negedge clock);
    rd_req = 1'b1; rd_addr = 4'd0;
    @(negedge clock);
    rd_req = 1'b0;
    check("rbw_done", done, 1);
    check("rbw_done_addr", done_addr, 0);
    check("rbw_done_data", done_data, 8'h3C);
    check("rbw_rd_valid", rd_valid, 1);
    check("rbw_old_data", rd_data, exp_mem[0]);
    exp_mem[0] = 8'h3C;
    do_read(4'd0, v, d);
    check("rbw_new_data", d, exp_mem[0]);

    // clear mid-operation at E0+3
    in_num = 4'b0101; in_key = 4'b0110; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("abort_in_ready", in_ready, 1);
    check("abort_count", count, 0);
    watch_no_done(10, seen);
    check("abort_no_done", seen, 0);
    do_read(4'd1, v, d);
    check("abort_rd1", d, exp_mem[1]);

    // Async reset mid-MUL
    do_op(4'b1111, 4'b1111, lat, a, d, low);
    check("pre_rst_addr", a, 0);
    check("pre_rst_data", d, 8'hE1);
    exp_mem[0] = 8'hE1;
    do_read(4'd0, v, d);
    check("pre_rst_rd", d, 8'hE1);
    in_num = 4'b0110; in_key = 4'b0111; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    repeat (4) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_done_data", done_data, 0);
    check("arst_rd_data", rd_data, 0);
    @(negedge clock);
    reset_n = 1'b1;
    watch_no_done(12, seen);
    check("arst_no_done", seen, 0);
    check("arst_count_after", count, 0);
    check("arst_in_ready", in_ready, 1);
    do_read(4'd1, v, d);
    check("arst_rd1", d, exp_mem[1]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
